// File: rtl/trace_cmd_queue.sv
// Trace command queue between the stimulus reader and the cache controller. It drops
// illegal opcodes, splits addresses into fields and tracks end-of-trace drain.
// Optional feature macro: CMDQ_DROP_COUNT_EN (counts dropped illegal opcodes).
module trace_cmd_queue #(
    parameter int DEPTH       = 4,
    parameter int INDEX_BITS  = 14,
    parameter int OFFSET_BITS = 6,
    localparam int TAG_BITS   = 32 - INDEX_BITS - OFFSET_BITS
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                n,
    input  logic [31:0]               add_in,
    input  logic                      done,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [3:0]                cmd_op,
    output logic [TAG_BITS-1:0]       cmd_tag,
    output logic [INDEX_BITS-1:0]     cmd_index,
    output logic [OFFSET_BITS-1:0]    cmd_offset,
    output logic [31-OFFSET_BITS:0]   add_out,
    output logic                      drained,
    output logic [15:0]               drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FINISHED} state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] addr;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           head_entry;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             op_legal, accept, push, pop;

    always_comb begin
        case (n)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9: op_legal = 1'b1;
            default:                                 op_legal = 1'b0;
        endcase
    end

    // in_ready looks only at registered state, so a pop never frees a slot in its own cycle.
    assign in_ready  = (state_q == ST_RUN) && (count_q < CNT_W'(DEPTH));
    assign cmd_valid = (count_q != '0);
    assign drained   = (state_q == ST_FINISHED);

    assign accept = in_valid && in_ready;
    assign push   = accept && op_legal;
    assign pop    = cmd_valid && cmd_ready;

    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;

        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_RUN:      if (done) state_d = ST_DRAIN;
            ST_DRAIN:    if (count_q == '0) state_d = ST_FINISHED;
            ST_FINISHED: state_d = ST_FINISHED;
            default:     state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (clear) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= ST_RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // NOTE: queue storage is deliberately not reset; cmd_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= '{op: n, addr: add_in};
    end

    assign head_entry = mem_q[head_q];
    assign cmd_op     = head_entry.op;
    assign cmd_tag    = head_entry.addr[31 -: TAG_BITS];
    assign cmd_index  = head_entry.addr[INDEX_BITS+OFFSET_BITS-1 : OFFSET_BITS];
    assign cmd_offset = head_entry.addr[OFFSET_BITS-1:0];
    assign add_out    = head_entry.addr[31:OFFSET_BITS];

`ifdef CMDQ_DROP_COUNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (accept && !op_legal && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (clear) drop_q <= '0;
        else       drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_trace_cmd_queue.sv
// Self-checking bench for trace_cmd_queue: a scoreboard queue holds accepted legal
// commands and is compared against the head fields whenever the controller pops.
module tb_trace_cmd_queue;

    logic        clk;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  n;
    logic [31:0] add_in;
    logic        done;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [11:0] cmd_tag;
    logic [13:0] cmd_index;
    logic [5:0]  cmd_offset;
    logic [25:0] add_out;
    logic        drained;
    logic [15:0] drop_count;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef CMDQ_DROP_COUNT_EN
    localparam logic [15:0] DROP_ONE = 16'd1;
`else
    localparam logic [15:0] DROP_ONE = 16'd0;
`endif

    trace_cmd_queue dut (
        .clk        (clk),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .n          (n),
        .add_in     (add_in),
        .done       (done),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_tag    (cmd_tag),
        .cmd_index  (cmd_index),
        .cmd_offset (cmd_offset),
        .add_out    (add_out),
        .drained    (drained),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};
    endfunction

    // One clock: record handshakes seen before the edge, then sample #1 after it.
    task automatic cycle();
        bit   acc;
        bit   pp;
        exp_t e;
        acc = in_valid && in_ready;
        pp  = cmd_valid && cmd_ready;
        if (pp) begin
            check("pop_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("head_op",     32'(cmd_op),     32'(e.op));
                check("head_tag",    32'(cmd_tag),    32'(e.addr[31:20]));
                check("head_index",  32'(cmd_index),  32'(e.addr[19:6]));
                check("head_offset", 32'(cmd_offset), 32'(e.addr[5:0]));
                check("head_line",   32'(add_out),    32'(e.addr[31:6]));
            end
        end
        if (acc && is_legal(n)) sb.push_back('{op: n, addr: add_in});
        @(posedge clk);
        #1;
        if (clear) sb.delete();
    endtask

    task automatic push_wait(input logic [3:0] op, input logic [31:0] a);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        n        = op;
        add_in   = a;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) ok = 1'b1;
            cycle();
            if (ok) break;
        end
        in_valid = 1'b0;
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear     = 1'b1;
        in_valid  = 1'b0;
        n         = '0;
        add_in    = '0;
        done      = 1'b0;
        cmd_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        clear = 1'b0;

        // Reset values
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_cmd_valid", 32'(cmd_valid),  32'd0);
        check("rst_drained",   32'(drained),    32'd0);
        check("rst_drop",      32'(drop_count), 32'd0);

        // Field split, one-cycle latency
        push_wait(4'd0, 32'h1234_5678);
        check("lat_valid",  32'(cmd_valid),  32'd1);
        check("lat_op",     32'(cmd_op),     32'd0);
        check("lat_tag",    32'(cmd_tag),    32'h123);
        check("lat_index",  32'(cmd_index),  32'h1159);
        check("lat_offset", 32'(cmd_offset), 32'h38);
        check("lat_line",   32'(add_out),    32'h048D159);
        cmd_ready = 1'b1;
        cycle();
        cmd_ready = 1'b0;
        check("lat_empty", 32'(cmd_valid), 32'd0);

        // Fill to DEPTH, fifth command held by the source
        for (int i = 0; i < 4; i++) push_wait(4'(i), $urandom());
        check("full_in_ready", 32'(in_ready),  32'd0);
        check("full_valid",    32'(cmd_valid), 32'd1);
        in_valid = 1'b1;
        n        = 4'd8;
        add_in   = $urandom();
        repeat (2) cycle();
        check("full_held", 32'(in_ready), 32'd0);
        cmd_ready = 1'b1;
        check("pop_cycle_in_ready", 32'(in_ready), 32'd0);
        cycle();
        cmd_ready = 1'b0;
        check("after_pop_in_ready", 32'(in_ready), 32'd1);
        cycle();
        in_valid = 1'b0;
        check("refill_in_ready", 32'(in_ready), 32'd0);
        cmd_ready = 1'b1;
        repeat (4) cycle();
        cmd_ready = 1'b0;
        check("fill_drained_empty", 32'(cmd_valid), 32'd0);

        // Illegal opcode dropped
        push_wait(4'd7, 32'hDEAD_BEEF);
        check("illegal_not_stored", 32'(cmd_valid), 32'd0);
        push_wait(4'd9, 32'hCAFE_F00D);
        check("legal_after_illegal", 32'(cmd_op),     32'd9);
        check("drop_count_one",      32'(drop_count), 32'(DROP_ONE));
        cmd_ready = 1'b1;
        cycle();
        cmd_ready = 1'b0;

        // End-of-trace drain
        for (int i = 0; i < 3; i++) push_wait(4'(i + 2), $urandom());
        done = 1'b1;
        cycle();
        done = 1'b0;
        check("drain_in_ready", 32'(in_ready),  32'd0);
        check("drain_valid",    32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        repeat (3) cycle();
        cmd_ready = 1'b0;
        check("drain_empty",       32'(cmd_valid), 32'd0);
        check("drain_not_yet",     32'(drained),   32'd0);
        cycle();
        check("drained_set",       32'(drained),   32'd1);
        in_valid = 1'b1;
        n        = 4'd1;
        repeat (3) cycle();
        in_valid = 1'b0;
        check("drained_held",      32'(drained),   32'd1);
        check("finished_in_ready", 32'(in_ready),  32'd0);
        check("finished_empty",    32'(cmd_valid), 32'd0);
        do_clear();
        check("clr_drained",  32'(drained),  32'd0);
        check("clr_in_ready", 32'(in_ready), 32'd1);

        // done in the same cycle as an accept: command still stored
        in_valid = 1'b1;
        n        = 4'd1;
        add_in   = 32'hA5A5_0040;
        done     = 1'b1;
        cycle();
        in_valid = 1'b0;
        done     = 1'b0;
        check("done_acc_valid",    32'(cmd_valid), 32'd1);
        check("done_acc_op",       32'(cmd_op),    32'd1);
        check("done_acc_in_ready", 32'(in_ready),  32'd0);
        cmd_ready = 1'b1;
        cycle();
        cmd_ready = 1'b0;
        do_clear();

        // Clear mid-operation
        push_wait(4'd12, 32'h0000_0001);
        push_wait(4'd2, $urandom());
        push_wait(4'd3, $urandom());
        check("pre_clr_drop",  32'(drop_count), 32'(DROP_ONE));
        check("pre_clr_valid", 32'(cmd_valid),  32'd1);
        do_clear();
        check("mid_clr_valid",    32'(cmd_valid),  32'd0);
        check("mid_clr_in_ready", 32'(in_ready),   32'd1);
        check("mid_clr_drained",  32'(drained),    32'd0);
        check("mid_clr_drop",     32'(drop_count), 32'd0);

        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
